// File: rtl/icache.sv
// ----------------------------------------------------------------------------
// icache
//
// Direct-mapped instruction cache holding one 32-bit word per line. It sits
// between the instruction fetcher and the memory controller. Hits are
// answered one cycle after the request is accepted. A miss issues a single
// word fetch and answers one cycle after the fill word arrives. A flush
// (clr) cancels the pending answer. A fetch already in flight still fills
// its line, so the cache contents stay consistent.
//
// Optional feature macro: ICACHE_PERF_EN
//   When it is defined, the outputs hit_cnt and miss_cnt are added. These are
//   32-bit wrapping counters of accepted, non-flushed requests.
//
// Handshake semantics (fetcher side):
//   The fetcher holds rn high, with a stable addr, until it sees Read_ready.
//   addr is captured only on the accepting edge. Read_ready is a registered
//   one-cycle pulse, and Inst is valid while it is high. rn is ignored in
//   the response cycle. A request that arrives together with clr is dropped.
//   A request that is flushed later is never answered.
// Handshake semantics (memory side):
//   mem_req is a level that stays high until mem_done, which is a one-cycle
//   pulse. mem_data is valid with mem_done. mem_addr is held for the whole
//   request.
//
// Ports
//   clk         system clock
//   rst         synchronous active-low reset
//   rdy         global ready; low freezes all state and outputs
//   clr         flush from the flow controller
//   addr        fetch byte address (bits [1:0] and above ADDR_W-1 ignored)
//   rn          read request level
//   Inst        instruction word, valid with Read_ready
//   Read_ready  one-cycle response pulse
//   mem_req     word fetch request to the memory controller
//   mem_addr    word-aligned fetch address
//   mem_data    fetched word
//   mem_done    fetch completion pulse
//   hit_cnt     (ICACHE_PERF_EN) accepted hits
//   miss_cnt    (ICACHE_PERF_EN) accepted misses, aborted ones included
//   o_dbg_state current FSM state: 0 IDLE, 1 MISS, 2 RESP, 3 ABORT
// ----------------------------------------------------------------------------
module icache #(
    parameter int LINE_NUM = 64,
    parameter int ADDR_W   = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic [31:0] addr,
    input  logic        rn,
    output logic [31:0] Inst,
    output logic        Read_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_done,
`ifdef ICACHE_PERF_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    output logic [1:0]  o_dbg_state
);

    localparam int IDX   = $clog2(LINE_NUM);
    localparam int TAG_W = ADDR_W - IDX - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        RESP  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t             r_state;
    logic [LINE_NUM-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag_mem  [LINE_NUM];
    logic [31:0]        r_data_mem [LINE_NUM];
    logic [IDX-1:0]     r_idx;
    logic [TAG_W-1:0]   r_tag;

    logic [IDX-1:0]     w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic [31:0]        w_mem_addr;
    logic               w_fill;
    logic               w_unused_addr;

    assign w_idx      = addr[IDX+1:2];
    assign w_tag      = addr[ADDR_W-1:IDX+2];
    assign w_hit      = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);
    assign w_mem_addr = {{(32-ADDR_W){1'b0}}, addr[ADDR_W-1:2], 2'b00};
    // These address bits take no part in the lookup.
    assign w_unused_addr = ^{addr[31:ADDR_W], addr[1:0]};

    // A fill happens whenever the outstanding fetch completes. This covers
    // the flushed (ABORT) case too, so the line never holds stale data.
    assign w_fill = rst && rdy && mem_done && ((r_state == MISS) || (r_state == ABORT));

    assign o_dbg_state = r_state;

    // The tag and data arrays have no reset. Lines stay unusable until they
    // are marked valid.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data_mem[r_idx] <= mem_data;
            r_tag_mem[r_idx]  <= r_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            r_idx      <= '0;
            r_tag      <= '0;
            Inst       <= '0;
            Read_ready <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
`ifdef ICACHE_PERF_EN
            hit_cnt    <= '0;
            miss_cnt   <= '0;
`endif
        end else if (rdy) begin
            case (r_state)
                IDLE: begin
                    // clr wins over rn; the request is silently dropped.
                    if (!clr && rn) begin
                        if (w_hit) begin
                            Inst       <= r_data_mem[w_idx];
                            Read_ready <= 1'b1;
                            r_state    <= RESP;
`ifdef ICACHE_PERF_EN
                            hit_cnt    <= hit_cnt + 32'd1;
`endif
                        end else begin
                            r_idx    <= w_idx;
                            r_tag    <= w_tag;
                            mem_req  <= 1'b1;
                            mem_addr <= w_mem_addr;
                            r_state  <= MISS;
`ifdef ICACHE_PERF_EN
                            miss_cnt <= miss_cnt + 32'd1;
`endif
                        end
                    end
                end
                MISS: begin
                    if (mem_done) begin
                        r_valid[r_idx] <= 1'b1;
                        mem_req        <= 1'b0;
                        if (clr) begin
                            r_state <= IDLE;
                        end else begin
                            Inst       <= mem_data;
                            Read_ready <= 1'b1;
                            r_state    <= RESP;
                        end
                    end else if (clr) begin
                        // The memory controller cannot be cancelled. Keep
                        // mem_req up and absorb the fill without answering.
                        r_state <= ABORT;
                    end
                end
                ABORT: begin
                    if (mem_done) begin
                        r_valid[r_idx] <= 1'b1;
                        mem_req        <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                RESP: begin
                    Read_ready <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// ----------------------------------------------------------------------------
// tb_icache: directed, table-driven bench for icache (LINE_NUM=64, ADDR_W=18).
// Expected instructions are pushed into exp_q when a request is accepted and
// popped when Read_ready is seen. Inputs change #1 after the rising edge, and
// outputs are checked at that same point.
// ----------------------------------------------------------------------------
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic [31:0] addr;
    logic        rn;
    logic [31:0] Inst;
    logic        Read_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_done;
    logic [1:0]  o_dbg_state;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int exp_hits = 0;
    int exp_miss = 0;
    logic [31:0] exp_q[$];

    icache dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clr         (clr),
        .addr        (addr),
        .rn          (rn),
        .Inst        (Inst),
        .Read_ready  (Read_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_done    (mem_done),
`ifdef ICACHE_PERF_EN
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt),
`endif
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called right after the edge that raised Read_ready.
    task automatic check_response(input string name);
        logic [31:0] e;
        chk({name, " read_ready"}, {31'd0, Read_ready}, 32'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s scoreboard: got a response, expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, " inst"}, Inst, e);
        end
        rn = 1'b0;
        tick();
        chk({name, " pulse_end"}, {31'd0, Read_ready}, 32'd0);
    endtask

    // One complete fetch. On a miss, mem_done arrives lat cycles after mem_req
    // is seen.
    task automatic do_fetch(input string name, input logic [31:0] a, input logic [31:0] d,
                            input int lat, input bit hit, input logic [31:0] inst);
        logic [31:0] exp_maddr;
        exp_maddr = {14'b0, a[17:2], 2'b00};
        addr = a;
        rn   = 1'b1;
        tick();
        exp_q.push_back(inst);
        if (hit) begin
            exp_hits++;
            chk({name, " no_mem_req"}, {31'd0, mem_req}, 32'd0);
            check_response(name);
        end else begin
            exp_miss++;
            chk({name, " miss_no_rr"}, {31'd0, Read_ready}, 32'd0);
            chk({name, " mem_req"}, {31'd0, mem_req}, 32'd1);
            chk({name, " mem_addr"}, mem_addr, exp_maddr);
            for (int i = 0; i < lat; i++) begin
                tick();
                chk({name, " mem_req_held"}, {31'd0, mem_req}, 32'd1);
            end
            mem_data = d;
            mem_done = 1'b1;
            tick();
            mem_done = 1'b0;
            chk({name, " mem_req_drop"}, {31'd0, mem_req}, 32'd0);
            check_response(name);
        end
    endtask

    task automatic check_counters(input string name);
`ifdef ICACHE_PERF_EN
        chk({name, " hit_cnt"}, hit_cnt, exp_hits);
        chk({name, " miss_cnt"}, miss_cnt, exp_miss);
`else
        if (name.len() == 0) $display("counter check skipped");
`endif
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        bit          hit;
        logic [31:0] inst;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{"v0_first_miss",   32'h0000_0000, 32'h0000_0093, 3, 1'b0, 32'h0000_0093};
        vecs[1]  = '{"v1_rehit",        32'h0000_0000, 32'h0,         0, 1'b1, 32'h0000_0093};
        vecs[2]  = '{"v2_conflict",     32'h0000_0100, 32'h1111_1111, 2, 1'b0, 32'h1111_1111};
        vecs[3]  = '{"v3_evicted",      32'h0000_0000, 32'h2222_2222, 2, 1'b0, 32'h2222_2222};
        vecs[4]  = '{"v4_evicted2",     32'h0000_0100, 32'h3333_3333, 1, 1'b0, 32'h3333_3333};
        vecs[5]  = '{"v5_miss8",        32'h0000_0008, 32'h4444_4444, 1, 1'b0, 32'h4444_4444};
        vecs[6]  = '{"v6_hit8",         32'h0000_0008, 32'h0,         0, 1'b1, 32'h4444_4444};
        vecs[7]  = '{"v7_upper_ignored",32'hFFFC_0008, 32'h0,         0, 1'b1, 32'h4444_4444};
        vecs[8]  = '{"v8_low_ignored",  32'h0000_000B, 32'h0,         0, 1'b1, 32'h4444_4444};
        vecs[9]  = '{"v9_top_addr",     32'h0003_FFFC, 32'h5555_5555, 0, 1'b0, 32'h5555_5555};
        vecs[10] = '{"v10_top_hit",     32'h0003_FFFC, 32'h0,         0, 1'b1, 32'h5555_5555};
        vecs[11] = '{"v11_idx63",       32'h0000_00FC, 32'h6666_6666, 2, 1'b0, 32'h6666_6666};
        vecs[12] = '{"v12_idx63_hit",   32'h0000_00FC, 32'h0,         0, 1'b1, 32'h6666_6666};
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0; rdy = 1'b1; clr = 1'b0; addr = '0; rn = 1'b0;
        mem_data = '0; mem_done = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk("reset inst", Inst, 32'd0);
        chk("reset read_ready", {31'd0, Read_ready}, 32'd0);
        chk("reset mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset state", {30'd0, o_dbg_state}, 32'd0);
        check_counters("reset");

        for (int i = 0; i < 13; i++)
            do_fetch(vecs[i].name, vecs[i].a, vecs[i].d, vecs[i].lat, vecs[i].hit, vecs[i].inst);
        check_counters("after_table");

        // clr during a miss: the pending answer is dropped but the fill still lands.
        addr = 32'h0000_0004; rn = 1'b1;
        tick();
        exp_miss++;
        chk("abort mem_req", {31'd0, mem_req}, 32'd1);
        clr = 1'b1; rn = 1'b0;
        tick();
        clr = 1'b0;
        chk("abort state", {30'd0, o_dbg_state}, 32'd3);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("abort mem_req_held", {31'd0, mem_req}, 32'd1);
            chk("abort no_rr", {31'd0, Read_ready}, 32'd0);
        end
        mem_data = 32'h7777_7777; mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("abort done mem_req", {31'd0, mem_req}, 32'd0);
        chk("abort done no_rr", {31'd0, Read_ready}, 32'd0);
        tick();
        chk("abort later no_rr", {31'd0, Read_ready}, 32'd0);
        chk("abort idle", {30'd0, o_dbg_state}, 32'd0);
        do_fetch("abort_refetch", 32'h0000_0004, 32'h0, 0, 1'b1, 32'h7777_7777);

        // clr and mem_done in the same MISS cycle: fill, no answer, back to IDLE.
        addr = 32'h0000_0010; rn = 1'b1;
        tick();
        exp_miss++;
        rn = 1'b0;
        clr = 1'b1; mem_done = 1'b1; mem_data = 32'h8888_8888;
        tick();
        clr = 1'b0; mem_done = 1'b0;
        chk("clrdone no_rr", {31'd0, Read_ready}, 32'd0);
        chk("clrdone mem_req", {31'd0, mem_req}, 32'd0);
        chk("clrdone state", {30'd0, o_dbg_state}, 32'd0);
        do_fetch("clrdone_refetch", 32'h0000_0010, 32'h0, 0, 1'b1, 32'h8888_8888);

        // clr together with rn in IDLE: the request is never taken.
        addr = 32'h0000_0200; rn = 1'b1; clr = 1'b1;
        tick();
        rn = 1'b0; clr = 1'b0;
        chk("clr_rn mem_req", {31'd0, mem_req}, 32'd0);
        chk("clr_rn no_rr", {31'd0, Read_ready}, 32'd0);
        tick();
        chk("clr_rn still_idle", {30'd0, o_dbg_state}, 32'd0);
        chk("clr_rn mem_req2", {31'd0, mem_req}, 32'd0);

        // rdy low in RESP freezes the pulse.
        addr = 32'h0000_0008; rn = 1'b1;
        tick();
        exp_hits++;
        chk("freeze rr", {31'd0, Read_ready}, 32'd1);
        rn = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("freeze rr_held", {31'd0, Read_ready}, 32'd1);
            chk("freeze inst", Inst, 32'h4444_4444);
        end
        rdy = 1'b1;
        tick();
        chk("freeze rr_drop", {31'd0, Read_ready}, 32'd0);
        check_counters("before_reset");

        // Reset in the middle of a miss, after lines are filled.
        addr = 32'h0000_0020; rn = 1'b1;
        tick();
        rn = 1'b0;
        chk("midmiss mem_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_hits = 0; exp_miss = 0;
        chk("rst2 mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst2 mem_addr", mem_addr, 32'd0);
        chk("rst2 inst", Inst, 32'd0);
        chk("rst2 rr", {31'd0, Read_ready}, 32'd0);
        chk("rst2 state", {30'd0, o_dbg_state}, 32'd0);
        check_counters("rst2");
        do_fetch("post_rst0", 32'h0000_0000, 32'hAAAA_0001, 1, 1'b0, 32'hAAAA_0001);
        do_fetch("post_rst8", 32'h0000_0008, 32'hAAAA_0002, 1, 1'b0, 32'hAAAA_0002);
        check_counters("post_rst");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and the memory controller. Accepts the fetcher's word read request (`addr`/`rn`), answers hits in one cycle and misses after one memory-controller word fetch, and returns the instruction with a one-cycle `Read_ready` pulse. Flushes from the flow controller cancel the pending response without corrupting cache contents.

## Interface
- `LINE_NUM`, 64: number of lines; power of two, ≥2.
- `ADDR_W`, 18: significant byte-address bits; `addr[ADDR_W-1:0]` used, upper bits ignored.
- `clk` input 1: system clock.
- `rst` input 1: reset; one clock, reset is synchronous and active-low.
- `rdy` input 1: global ready; low freezes all state and outputs.
- `clr` input 1: flush from flow controller.
- `addr` input 32: fetch byte address; bits [1:0] ignored.
- `rn` input 1: read request level, held by fetcher until `Read_ready`.
- `Inst` output 32: instruction word, valid while `Read_ready`=1.
- `Read_ready` output 1: one-cycle response pulse.
- `mem_req` output 1: word fetch request level to memory controller.
- `mem_addr` output 32: word-aligned fetch address, `{14'b0, addr[ADDR_W-1:2], 2'b00}` for defaults.
- `mem_data` input 32: fetched word, valid with `mem_done`.
- `mem_done` input 1: one-cycle completion pulse.

## Operation
- Address split: index = `addr[IDX+1:2]`, IDX = log2(LINE_NUM); tag = `addr[ADDR_W-1:IDX+2]`. Arrays: `valid[LINE_NUM]`, tag, data.
- States: IDLE, MISS, RESP, ABORT.
- IDLE: if `clr` → stay IDLE. Else if `rn`: hit (valid & tag match) → `Inst`←data, `Read_ready`←1, → RESP; miss → latch index/tag, `mem_req`←1, `mem_addr`←aligned addr, → MISS.
- MISS: on `mem_done` → write data/tag, set valid, `Inst`←`mem_data`, `Read_ready`←1, `mem_req`←0, → RESP. If `clr` (no `mem_done`) → ABORT, `mem_req` held. If `clr` and `mem_done` together → fill line, no response, → IDLE.
- ABORT: `mem_req` held; on `mem_done` fill line, `mem_req`←0, no response, → IDLE.
- RESP: `Read_ready`←0, → IDLE; `rn` ignored this cycle (fetcher drops `rn` one edge after seeing the pulse). `clr` in RESP → IDLE too.
- `clr` priority over `rn` in same cycle; a flushed request is never answered.
- `rdy`=0: no state, array or output change; `mem_done` must not occur while `rdy`=0.
- `addr` sampled only at request acceptance; later changes ignored.

## Timing
- Reset (`rst`=0 at edge): all `valid`←0, state IDLE, `Inst`=0, `Read_ready`=0, `mem_req`=0, `mem_addr`=0. Reset mid-miss abandons the request (memory controller reset together).
- Hit: `rn` sampled at edge E → `Read_ready`=1 during cycle E..E+1, 0 after E+1.
- Miss: `mem_req` rises after E; `mem_done` at edge M → `Read_ready`=1 during cycle M..M+1. Latency = memory latency + 1.
- Back-to-back: next request accepted no earlier than edge E+2 (hit) / M+2 (miss).
- Same-index different-tag refill overwrites the old line (no replacement choice).

## Configuration
- `ICACHE_PERF_EN` defined: adds outputs `hit_cnt` and `miss_cnt` (32-bit, reset 0, wrap at 2^32), incremented at acceptance of each non-flushed request; aborted misses count as misses.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset then `rn`=1, `addr`=0x0000: miss, `mem_addr`=0x0, `mem_done` with 0x00000093 after 3 cycles → `Read_ready` 1 pulse, `Inst`=0x00000093.
- Re-request 0x0000 → `Read_ready` one cycle after acceptance, no `mem_req`; `hit_cnt`=1, `miss_cnt`=1 with `ICACHE_PERF_EN`.
- Conflict: fill 0x0000, fetch 0x0100 (same index, LINE_NUM=64) → miss; refetch 0x0000 → miss again.
- `clr` during MISS for 0x0004 → no `Read_ready`, `mem_req` held to `mem_done`; later fetch 0x0004 hits with filled data.
- `clr` and `rn` same cycle in IDLE → no request, no `mem_req`; `rdy`=0 for 5 cycles during RESP → `Read_ready` stays 1, resumes then drops.
- `rst`=0 for one edge after filling lines → all subsequent fetches miss; outputs 0 after reset edge.
